// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// with DM priority bounded by a starvation counter that forces an IF grant.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_if_ready;
    logic               r_dm_ready;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_dm_rdata;

    logic w_idle;
    logic w_if_elig;
    logic w_dm_elig;
    logic w_starved;
    logic w_grant_if;
    logic w_grant_dm;

    // A request still high in its own ready cycle is the old one, not a new one.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_if_elig  = if_req & ~r_if_ready;
    assign w_dm_elig  = dm_req & ~r_dm_ready;
    assign w_starved  = (r_starve_cnt == CNT_MAX);
    assign w_grant_if = w_idle & w_if_elig & (~w_dm_elig | w_starved);
    assign w_grant_dm = w_idle & w_dm_elig & ~w_grant_if;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_if_ready   <= 1'b0;
            r_dm_ready   <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;

            if (!if_req || w_grant_if) begin
                r_starve_cnt <= '0;
            end else if (w_grant_dm && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_dm) begin
                        r_state     <= ST_BUSY_DM;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                    end else if (w_grant_if) begin
                        r_state    <= ST_BUSY_IF;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= if_addr;
                    end
                end
                ST_BUSY_IF: begin
                    if (mem_ack) begin
                        r_state    <= ST_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_if_ready <= 1'b1;
                        r_if_rdata <= mem_rdata;
                    end
                end
                ST_BUSY_DM: begin
                    if (mem_ack) begin
                        r_state    <= ST_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_dm_ready <= 1'b1;
                        if (!r_mem_we) begin
                            r_dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign stall_f   = if_req & ~r_if_ready;
    assign stall_m   = dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random requesters and memory against a cycle-level reference of the arbiter rules.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 2;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, stall_f, stall_m, mem_req, mem_we;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk(clk), .n_reset(n_reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs; owner: 0 = memory free, 1 = fetch in flight, 2 = data access in flight
    logic        e_req, e_we, e_if_rdy, e_dm_rdy;
    logic [31:0] e_addr, e_wdata, e_if_rd, e_dm_rd;
    int          owner, starve;

    task automatic model_reset();
        e_req = 0; e_we = 0; e_if_rdy = 0; e_dm_rdy = 0;
        e_addr = 0; e_wdata = 0; e_if_rd = 0; e_dm_rd = 0;
        owner = 0; starve = 0;
    endtask

    // Advance the reference by one clock edge using the inputs presented this cycle.
    task automatic model_step();
        bit if_fresh, dm_fresh;
        int winner;
        if (!n_reset) begin
            model_reset();
            return;
        end
        if_fresh = if_req && !e_if_rdy;
        dm_fresh = dm_req && !e_dm_rdy;
        e_if_rdy = 0;
        e_dm_rdy = 0;
        winner = 0;
        if (owner == 0) begin
            if (if_fresh && dm_fresh) winner = (starve == LIMIT) ? 1 : 2;
            else if (dm_fresh)        winner = 2;
            else if (if_fresh)        winner = 1;
        end
        if (!if_req || winner == 1) starve = 0;
        else if (winner == 2)       starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;

        if (winner == 2) begin
            e_req = 1; e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata; owner = 2;
        end else if (winner == 1) begin
            e_req = 1; e_we = 0; e_addr = if_addr; owner = 1;
        end else if (owner != 0 && mem_ack) begin
            if (owner == 1) begin
                e_if_rdy = 1; e_if_rd = mem_rdata;
            end else begin
                e_dm_rdy = 1;
                if (!e_we) e_dm_rd = mem_rdata;
            end
            e_req = 0; e_we = 0; owner = 0;
        end
    endtask

    task automatic check_outputs();
        check("mem_req",   {31'd0, mem_req},  {31'd0, e_req});
        check("mem_we",    {31'd0, mem_we},   {31'd0, e_we});
        check("mem_addr",  mem_addr,          e_addr);
        check("mem_wdata", mem_wdata,         e_wdata);
        check("if_ready",  {31'd0, if_ready}, {31'd0, e_if_rdy});
        check("dm_ready",  {31'd0, dm_ready}, {31'd0, e_dm_rdy});
        check("if_rdata",  if_rdata,          e_if_rd);
        check("dm_rdata",  dm_rdata,          e_dm_rd);
        check("we_only_with_req", {31'd0, mem_we & ~mem_req}, 32'd0);
    endtask

    int  p_if, p_dm, wait_max, rst_pct;
    bit  in_txn;
    int  wait_left;

    task automatic drive_inputs();
        n_reset = ($urandom_range(0, 99) < rst_pct) ? 1'b0 : 1'b1;
        // Requesters hold their request until it completes, then decide afresh.
        if (!(if_req && !e_if_rdy)) begin
            if_req  = ($urandom_range(0, 99) < p_if);
            if_addr = $urandom;
        end
        if (!(dm_req && !e_dm_rdy)) begin
            dm_req   = ($urandom_range(0, 99) < p_dm);
            dm_we    = $urandom_range(0, 1) == 1;
            dm_addr  = $urandom;
            dm_wdata = $urandom;
        end
        // Memory: acks after a random wait; stray acks while idle must be ignored.
        mem_rdata = $urandom;
        if (!e_req) begin
            in_txn  = 0;
            mem_ack = ($urandom_range(0, 3) == 0);
        end else begin
            if (!in_txn) begin
                in_txn    = 1;
                wait_left = $urandom_range(0, wait_max);
            end
            if (wait_left == 0) begin
                mem_ack = 1;
                in_txn  = 0;
            end else begin
                mem_ack = 0;
                wait_left--;
            end
        end
    endtask

    initial begin
        n_reset = 0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        in_txn = 0; wait_left = 0;
        model_reset();
        repeat (2) @(posedge clk);

        for (int phase = 0; phase < 4; phase++) begin
            case (phase)
                0:       begin p_if = 70; p_dm = 70; wait_max = 0; rst_pct = 0; end
                1:       begin p_if = 50; p_dm = 50; wait_max = 3; rst_pct = 0; end
                2:       begin p_if = 60; p_dm = 60; wait_max = 2; rst_pct = 4; end
                default: begin p_if = 80; p_dm = 0;  wait_max = 1; rst_pct = 0; end
            endcase
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                check_outputs();
                drive_inputs();
                #1;
                check("stall_f", {31'd0, stall_f}, {31'd0, if_req & ~e_if_rdy});
                check("stall_m", {31'd0, stall_m}, {31'd0, dm_req & ~e_dm_rdy});
                model_step();
            end
        end

        @(negedge clk);
        check_outputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
